// File: rtl/data_ram_arbiter.sv
// Two-port arbiter and access sequencer in front of a word-wide data RAM.
// Handles sub-word loads by lane extraction and sub-word stores by read-modify-write.
module data_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_size,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_size,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wr_data,
  output logic              ram_wr_en,
  input  logic [31:0]       ram_rd_data,

  output logic              busy
);

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_R = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t            state;
  logic              owner_q;   // 0 = m0, 1 = m1
  logic              rr_last;   // requester granted most recently
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              pick_m1;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [31:0]       sel_wdata;
  logic              sel_err;

  // Zero-extended byte/half lane of a RAM word; full word otherwise.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size);
    logic [31:0] res;
    res = '0;
    case (size)
      SIZE_B:  res[7:0]  = word[{lo, 3'b000} +: 8];
      SIZE_H:  res[15:0] = word[{lo[1], 4'b0000} +: 16];
      default: res       = word;
    endcase
    return res;
  endfunction

  // Old RAM word with the addressed lane replaced by right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  size);
    logic [31:0] res;
    res = word;
    case (size)
      SIZE_B:  res[{lo, 3'b000} +: 8]     = wdata[7:0];
      SIZE_H:  res[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: res                         = wdata;
    endcase
    return res;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_m1 = 1'b0;
    if (RR_EN)
      pick_m1 = m1_req && (!m0_req || !rr_last);
    else
      pick_m1 = m1_req && !m0_req;

    // Gated by rst_n so grants stay low while reset is held.
    grant     = rst_n && (state == IDLE) && (m0_req || m1_req);
    sel_we    = pick_m1 ? m1_we    : m0_we;
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_size  = pick_m1 ? m1_size  : m0_size;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    sel_err   = (sel_size == SIZE_R)
             || ((sel_size == SIZE_H) && sel_addr[0])
             || ((sel_size == SIZE_W) && (sel_addr[1:0] != 2'b00));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and evaluation order cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      rr_last <= 1'b1;
      addr_q  <= '0;
      size_q  <= SIZE_B;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner_q <= pick_m1;
            rr_last <= pick_m1;
            addr_q  <= sel_addr;
            size_q  <= sel_size;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            err_q   <= sel_err;
            if (sel_err)
              state <= RESP;
            else if (!sel_we)
              state <= RD;
            else if (sel_size == SIZE_W)
              state <= WR;
            else
              state <= RMW_RD;
          end
        end
        RD: begin
          rdata_q <= lane_extract(ram_rd_data, addr_q[1:0], size_q);
          state   <= RESP;
        end
        RMW_RD: begin
          word_q <= ram_rd_data;
          state  <= WR;
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic resp;
  assign resp = (state == RESP);

  assign busy        = (state != IDLE);
  assign ram_addr    = (state == RD || state == RMW_RD || state == WR)
                     ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign ram_wr_en   = (state == WR);
  assign ram_wr_data = ram_wr_en ? lane_merge(word_q, wdata_q, addr_q[1:0], size_q) : '0;

  assign m0_gnt   = grant && !pick_m1;
  assign m1_gnt   = grant && pick_m1;
  assign m0_ack   = resp && !owner_q;
  assign m1_ack   = resp && owner_q;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
  assign m0_err   = m0_ack && err_q;
  assign m1_err   = m1_ack && err_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: a round-robin instance on a RAM model
// and a fixed-priority instance used only for the starvation scenario.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
  logic        ram_wr_en, busy;

  logic [31:0] mem [0:63];
  assign ram_rd_data = mem[ram_addr[7:2]];
  always @(posedge clk) if (ram_wr_en) mem[ram_addr[7:2]] <= ram_wr_data;

  data_ram_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data), .busy(busy)
  );

  logic        f_m0_req = 0, f_m1_req = 0;
  logic        f_m0_gnt, f_m0_ack, f_m0_err, f_m1_gnt, f_m1_ack, f_m1_err, f_wr_en, f_busy;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_ram_addr, f_wr_data;

  data_ram_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) u_fixed (
    .clk(clk), .rst_n(rst_n),
    .m0_req(f_m0_req), .m0_we(1'b0), .m0_addr(32'h10), .m0_size(2'b10), .m0_wdata(32'h0),
    .m0_gnt(f_m0_gnt), .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(f_m1_req), .m1_we(1'b0), .m1_addr(32'h10), .m1_size(2'b10), .m1_wdata(32'h0),
    .m1_gnt(f_m1_gnt), .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .ram_addr(f_ram_addr), .ram_wr_data(f_wr_data), .ram_wr_en(f_wr_en),
    .ram_rd_data(32'h0), .busy(f_busy)
  );

  int checks = 0;
  int errors = 0;

  // Runs one transaction on port p and reports cycle offsets relative to the request cycle.
  task automatic do_txn(input bit p, input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input bit drop_early,
                        output int gnt_c, output int ack_c, output int wr_c, output int wr_n,
                        output logic [31:0] rdata, output bit err);
    bit g, a;
    gnt_c = -1; ack_c = -1; wr_c = -1; wr_n = 0; rdata = 32'hxxxxxxxx; err = 1'b0;
    @(posedge clk); #1;
    if (p) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_size = size; m1_wdata = wdata; end
    else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_size = size; m0_wdata = wdata; end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      g = p ? m1_gnt : m0_gnt;
      a = p ? m1_ack : m0_ack;
      if (g && gnt_c < 0) gnt_c = c;
      if (ram_wr_en) begin wr_n++; wr_c = c; end
      if (a) begin ack_c = c; rdata = p ? m1_rdata : m0_rdata; err = p ? m1_err : m0_err; end
      @(posedge clk); #1;
      if ((g && drop_early) || a) begin m0_req = 0; m1_req = 0; end
      if (a) break;
    end
    m0_req = 0; m1_req = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 0;
    #3;
    rst_n = 1;
  endtask

  task automatic test_reset();
    m0_req = 1; m1_req = 1;
    #3;
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", m0_gnt, m1_gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ram_wr_en !== 1'b0 || ram_addr !== 32'h0) begin errors++; $display("FAIL reset_ram: wr_en %b addr %h want 0 0", ram_wr_en, ram_addr); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_ack: got %b%b rdata %h want 00 0", m0_ack, m1_ack, m0_rdata); end
    m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_word();
    int gc, ac, wc, wn; logic [31:0] rd; bit er;
    do_txn(0, 1, 32'h10, 2'b10, 32'hDEADBEEF, 0, gc, ac, wc, wn, rd, er);
    checks++; if (gc !== 0 || ac !== 2) begin errors++; $display("FAIL word_st_lat: gnt %0d ack %0d want 0 2", gc, ac); end
    checks++; if (wn !== 1 || wc !== 1) begin errors++; $display("FAIL word_st_wr: count %0d cycle %0d want 1 1", wn, wc); end
    checks++; if (mem[4] !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL word_st_mem: got %h err %b want deadbeef 0", mem[4], er); end
    do_txn(0, 0, 32'h10, 2'b10, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 2 || wn !== 0) begin errors++; $display("FAIL word_ld_lat: ack %0d writes %0d want 2 0", ac, wn); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL word_ld_data: got %h err %b want deadbeef 0", rd, er); end
  endtask

  task automatic test_byte_rmw();
    int gc, ac, wc, wn; logic [31:0] rd; bit er;
    do_txn(0, 1, 32'h10, 2'b10, 32'h11223344, 0, gc, ac, wc, wn, rd, er);
    do_txn(0, 1, 32'h12, 2'b00, 32'hFFFFFFAB, 0, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 3 || wc !== 2 || wn !== 1) begin errors++; $display("FAIL sb_lat: ack %0d wr %0d n %0d want 3 2 1", ac, wc, wn); end
    checks++; if (mem[4] !== 32'h11AB3344) begin errors++; $display("FAIL sb_mem: got %h want 11ab3344", mem[4]); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp: rdata %h err %b want 0 0", rd, er); end
    do_txn(0, 0, 32'h12, 2'b01, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (rd !== 32'h000011AB || ac !== 2) begin errors++; $display("FAIL lh_hi: got %h ack %0d want 000011ab 2", rd, ac); end
    do_txn(1, 0, 32'h13, 2'b00, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_3: got %h want 00000011", rd); end
    do_txn(0, 0, 32'h11, 2'b00, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (rd !== 32'h00000033) begin errors++; $display("FAIL lb_1: got %h want 00000033", rd); end
  endtask

  task automatic test_misaligned();
    int gc, ac, wc, wn; logic [31:0] rd; bit er;
    do_txn(1, 1, 32'h13, 2'b01, 32'h0000FFFF, 0, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 1 || er !== 1'b1) begin errors++; $display("FAIL sh_mis: ack %0d err %b want 1 1", ac, er); end
    checks++; if (wn !== 0 || mem[4] !== 32'h11AB3344 || rd !== 32'h0) begin errors++; $display("FAIL sh_mis_ram: writes %0d mem %h rdata %h want 0 11ab3344 0", wn, mem[4], rd); end
    do_txn(1, 0, 32'h10, 2'b11, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL size11: ack %0d err %b rdata %h want 1 1 0", ac, er, rd); end
    do_txn(0, 0, 32'h12, 2'b10, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 1 || er !== 1'b1) begin errors++; $display("FAIL lw_mis: ack %0d err %b want 1 1", ac, er); end
  endtask

  task automatic test_arbitration();
    int n = 0; int fm0 = 0; int fm1 = 0; bit done = 0;
    int gseq[4]; int gcyc[4];
    apply_reset();
    @(posedge clk); #1;
    m0_we = 0; m0_addr = 32'h10; m0_size = 2'b10;
    m1_we = 0; m1_addr = 32'h10; m1_size = 2'b10;
    m0_req = 1; m1_req = 1; f_m0_req = 1; f_m1_req = 1;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (f_m0_gnt) fm0++;
      if (f_m1_gnt) fm1++;
      if (m0_gnt) begin gseq[n] = 0; gcyc[n] = c; n++; end
      else if (m1_gnt) begin gseq[n] = 1; gcyc[n] = c; n++; end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0; f_m0_req = 0; f_m1_req = 0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d grants want 4", n); end
    if (n == 4) begin
      checks++; if (gseq[0] !== 0 || gseq[1] !== 1 || gseq[2] !== 0 || gseq[3] !== 1)
        begin errors++; $display("FAIL rr_order: got %0d%0d%0d%0d want 0101", gseq[0], gseq[1], gseq[2], gseq[3]); end
      checks++; if (gcyc[1] - gcyc[0] !== 3 || gcyc[3] - gcyc[2] !== 3)
        begin errors++; $display("FAIL b2b_spacing: got %0d %0d want 3 3", gcyc[1] - gcyc[0], gcyc[3] - gcyc[2]); end
    end
    checks++; if (fm0 !== 4 || fm1 !== 0) begin errors++; $display("FAIL fixed_prio: m0 %0d m1 %0d want 4 0", fm0, fm1); end
    for (int c = 0; c < 10 && !done; c++) begin
      @(posedge clk); #1;
      done = !busy && !f_busy;
    end
    checks++; if (!done) begin errors++; $display("FAIL arb_drain: busy %b %b want 0 0", busy, f_busy); end
  endtask

  task automatic test_reset_mid_rmw();
    int gc, ac, wc, wn; logic [31:0] rd; bit er; int bad = 0;
    do_txn(0, 1, 32'h10, 2'b10, 32'h11223344, 0, gc, ac, wc, wn, rd, er);
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_size = 2'b00; m0_wdata = 32'h55;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_rmw_gnt: got %b want 1", m0_gnt); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || ram_addr !== 32'h10 || ram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_rmw_rd: busy %b addr %h wr %b want 1 10 0", busy, ram_addr, ram_wr_en); end
    rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0 || ram_addr !== 32'h0 || ram_wr_en !== 1'b0 || m0_ack !== 1'b0 || m0_gnt !== 1'b0)
      begin errors++; $display("FAIL rst_rmw_out: busy %b addr %h wr %b ack %b gnt %b want all 0", busy, ram_addr, ram_wr_en, m0_ack, m0_gnt); end
    m0_req = 0;
    repeat (2) begin
      @(negedge clk);
      if (ram_wr_en || m0_ack) bad++;
    end
    rst_n = 1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_rmw_quiet: got %0d write/ack cycles want 0", bad); end
    do_txn(0, 0, 32'h10, 2'b10, 32'h0, 0, gc, ac, wc, wn, rd, er);
    checks++; if (rd !== 32'h11223344 || mem[4] !== 32'h11223344) begin errors++; $display("FAIL rst_rmw_old: rdata %h mem %h want 11223344", rd, mem[4]); end
  endtask

  task automatic test_drop_req();
    int gc, ac, wc, wn; logic [31:0] rd; bit er;
    do_txn(1, 1, 32'h14, 2'b10, 32'hAAAABBBB, 1, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 2 || wn !== 1 || mem[5] !== 32'hAAAABBBB) begin errors++; $display("FAIL drop_sw: ack %0d writes %0d mem %h want 2 1 aaaabbbb", ac, wn, mem[5]); end
    do_txn(0, 1, 32'h16, 2'b01, 32'h1234CAFE, 1, gc, ac, wc, wn, rd, er);
    checks++; if (ac !== 3 || wc !== 2 || wn !== 1) begin errors++; $display("FAIL drop_sh_lat: ack %0d wr %0d n %0d want 3 2 1", ac, wc, wn); end
    checks++; if (mem[5] !== 32'hCAFEBBBB) begin errors++; $display("FAIL drop_sh_mem: got %h want cafebbbb", mem[5]); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_rmw();
    test_misaligned();
    test_drop_req();
    test_arbitration();
    test_reset_mid_rmw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
